// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue and its storage.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam int          DEPTH_DEFAULT = 4;

endpackage

// File: rtl/sync_fifo.sv
// Pointer-based synchronous FIFO of fetch entries with flush; head is read combinationally.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 din,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH+1))'(DEPTH));
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited memory requests, in-order responses,
// and discarding of responses that were already in flight when a redirect happened.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic        InstrValidF
);

    localparam int           CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]  DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   pcf_hold;
    logic [31:0]   target_aligned;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [CW:0]   credit;
    logic          grant;
    logic          drop_active;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  head;
    fetch_entry_t  din;

    assign target_aligned = PCTargetE & ~32'h3;
    assign credit         = {1'b0, count} + {1'b0, outstanding};
    assign imem_req       = !reset && !PCSrcE && (credit < DEPTH_W);
    assign imem_addr      = fetch_pc;
    assign grant          = imem_req && imem_gnt;
    assign drop_active    = (drop_cnt != '0);
    assign push           = imem_rvalid && !drop_active && !PCSrcE && !reset && (!fifo_full || pop);
    assign InstrValidF    = !reset && !fifo_empty;
    assign pop            = InstrValidF && !StallF && !PCSrcE;
    assign din            = '{pc: resp_pc, instr: imem_rdata};

    assign InstrF = InstrValidF ? head.instr : NOP_INSTR;
    assign PCF    = reset ? RESET_PC : (fifo_empty ? pcf_hold : head.pc);

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (PCSrcE),
        .din   (din),
        .head  (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Outstanding keeps counting stale responses, so after a redirect drop_cnt
    // equals exactly the number of words still owed by memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            pcf_hold    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            if (!fifo_empty) pcf_hold <= head.pc;
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
            if (PCSrcE) begin
                fetch_pc <= target_aligned;
                resp_pc  <= target_aligned;
                drop_cnt <= outstanding - CW'(imem_rvalid);
            end else begin
                if (grant) fetch_pc <= fetch_pc + 32'd4;
                if (push)  resp_pc  <= resp_pc + 32'd4;
                if (imem_rvalid && drop_active) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: table-driven reset/stream/stall vectors plus
// redirect, alignment, wrap and mid-burst reset sequences, all backed by a scoreboard.
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic        InstrValidF;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    vec_t        vecs [26];
    pend_t       mq[$];
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    int          grant_count = 0;
    bit          hold = 0;
    bit          s_reset, s_rvalid, s_grant;
    logic [31:0] s_addr;
    logic [31:0] model_pc = RESET_PC;

    fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .InstrValidF (InstrValidF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_1000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic driveMem();
        if (!hold && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic setHold(input bit h);
        hold = h;
        driveMem();
    endtask

    // Samples mid-cycle, compares the head against the scoreboard and updates the models.
    task automatic sampleAndCheck();
        @(negedge clk);
        s_reset  = reset;
        s_rvalid = imem_rvalid;
        s_grant  = imem_req && imem_gnt;
        s_addr   = imem_addr;
        if (!reset) begin
            if (InstrValidF) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("[TB] FAIL sb_unexpected_valid: got valid PCF=%h expected no valid entry", PCF);
                end else begin
                    checkOutput("sb_pc", PCF, sb[0].pc);
                    checkOutput("sb_instr", InstrF, sb[0].instr);
                    if (!StallF && !PCSrcE) void'(sb.pop_front());
                end
            end else begin
                checkOutput("nop_when_empty", InstrF, NOP);
            end
            if (s_grant) begin
                checkOutput("fetch_addr", imem_addr, model_pc);
                model_pc = model_pc + 32'd4;
                grant_count++;
            end
            if (PCSrcE) begin
                checkOutput("req_in_redirect", {31'b0, imem_req}, 32'd0);
                sb.delete();
                foreach (mq[i]) mq[i].stale = 1'b1;
                model_pc = PCTargetE & ~32'h3;
            end
        end
    endtask

    task automatic finishCycle();
        pend_t p;
        pend_t n;
        exp_t  e;
        @(posedge clk);
        #1;
        if (s_reset) begin
            mq.delete();
            sb.delete();
            model_pc    = RESET_PC;
            grant_count = 0;
        end else begin
            if (s_rvalid) begin
                p = mq.pop_front();
                if (!p.stale) begin
                    e.pc    = p.addr;
                    e.instr = memWord(p.addr);
                    sb.push_back(e);
                end
            end
            if (s_grant) begin
                n.addr  = s_addr;
                n.due   = cyc + lat;
                n.stale = 1'b0;
                mq.push_back(n);
            end
        end
        cyc++;
        driveMem();
    endtask

    task automatic tick();
        sampleAndCheck();
        finishCycle();
    endtask

    // Returns mid-cycle with InstrValidF seen, or flags a timeout.
    task automatic waitValid(input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            sampleAndCheck();
            if (InstrValidF) found = 1'b1;
            else finishCycle();
        end
        if (!found) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL %s: got no valid instruction expected one within %0d cycles", name, budget);
            sampleAndCheck();
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset    = v.rst;
        StallF   = v.stall;
        PCSrcE   = 1'b0;
        imem_gnt = 1'b1;
    endtask

    initial begin
        // Stream from reset, then stall until the credit limit blocks requests.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h04};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h08};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0C};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h10};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h10};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h10};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h14};
        // Reset, then stall from the first cycle: exactly four grants.
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h00};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h00};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00};
        vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00};
        vecs[25] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h04};

        reset       = 1'b1;
        StallF      = 1'b0;
        PCSrcE      = 1'b0;
        PCTargetE   = 32'h0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        tick();
        tick();

        for (int i = 0; i < 26; i++) begin
            applyStimulus(vecs[i]);
            sampleAndCheck();
            checkOutput($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
            checkOutput($sformatf("vec%0d_valid", i), {31'b0, InstrValidF}, {31'b0, vecs[i].exp_valid});
            checkOutput($sformatf("vec%0d_pcf", i), PCF, vecs[i].exp_pc);
            checkOutput($sformatf("vec%0d_instr", i), InstrF,
                        vecs[i].exp_valid ? memWord(vecs[i].exp_pc) : NOP);
            finishCycle();
            if (i == 23) checkOutput("stall_grants", grant_count, 32'd4);
        end

        // Redirect with three fetches in flight; their words must all be dropped.
        StallF = 1'b0;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        setHold(1'b1);
        tick();
        tick();
        tick();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0100;
        tick();
        PCSrcE = 1'b0;
        sampleAndCheck();
        checkOutput("redirect_addr", imem_addr, 32'h0000_0100);
        finishCycle();
        setHold(1'b0);
        waitValid(20, "redirect_valid");
        checkOutput("redirect_pcf", PCF, 32'h0000_0100);
        checkOutput("redirect_instr", InstrF, memWord(32'h0000_0100));
        finishCycle();

        // Second redirect lands while the drop counter is busy and a stale word arrives.
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0200;
        setHold(1'b1);
        tick();
        setHold(1'b0);
        PCTargetE = 32'h0000_0300;
        tick();
        PCSrcE = 1'b0;
        waitValid(20, "redirect2_valid");
        checkOutput("redirect2_pcf", PCF, 32'h0000_0300);
        finishCycle();

        // Low target bits are ignored.
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0103;
        tick();
        PCSrcE = 1'b0;
        sampleAndCheck();
        checkOutput("aligned_addr", imem_addr, 32'h0000_0100);
        finishCycle();
        waitValid(20, "aligned_valid");
        checkOutput("aligned_pcf", PCF, 32'h0000_0100);
        finishCycle();

        // Fetch address wraps past the top of the address space.
        PCSrcE    = 1'b1;
        PCTargetE = 32'hFFFF_FFFC;
        tick();
        PCSrcE = 1'b0;
        sampleAndCheck();
        checkOutput("wrap_req", {31'b0, imem_req}, 32'd1);
        checkOutput("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        finishCycle();
        sampleAndCheck();
        checkOutput("wrap_addr_zero", imem_addr, 32'h0000_0000);
        finishCycle();
        waitValid(20, "wrap_valid");
        checkOutput("wrap_pcf", PCF, 32'hFFFF_FFFC);
        finishCycle();
        for (int i = 0; i < 4; i++) tick();

        // One-cycle reset in the middle of a two-deep burst.
        lat = 2;
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sampleAndCheck();
        checkOutput("post_reset_req", {31'b0, imem_req}, 32'd1);
        checkOutput("post_reset_addr", imem_addr, RESET_PC);
        checkOutput("post_reset_valid", {31'b0, InstrValidF}, 32'd0);
        checkOutput("post_reset_instr", InstrF, NOP);
        checkOutput("post_reset_pcf", PCF, RESET_PC);
        finishCycle();
        waitValid(20, "post_reset_valid_wait");
        checkOutput("post_reset_first_pcf", PCF, RESET_PC);
        finishCycle();
        for (int i = 0; i < 6; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of FIFO entries and the maximum number of outstanding fetches; legal range 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch byte address, word-aligned.
REQ-007 imem_gnt  input  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1  response data valid; responses arrive in request order.
REQ-009 imem_rdata  input  32  response instruction word.
REQ-010 StallF  input  1  core holds its fetch stage; no instruction is consumed.
REQ-011 PCSrcE  input  1  redirect from the execute stage (taken branch or jump).
REQ-012 PCTargetE  input  32  redirect target address.
REQ-013 InstrF  output  32  instruction at the queue head.
REQ-014 PCF  output  32  PC of the head instruction.
REQ-015 InstrValidF  output  1  head entry valid.

Function
REQ-016 The block SHALL keep fetch_pc, credit = count + outstanding, and drop_cnt, plus a DEPTH-entry FIFO of {pc, instr}.
REQ-017 imem_req SHALL be 1 iff reset=0, PCSrcE=0, and count + outstanding < DEPTH; imem_addr SHALL equal fetch_pc.
REQ-018 On imem_req & imem_gnt, fetch_pc SHALL advance by 4, wrapping modulo 2^32, and outstanding SHALL increment.
REQ-019 On imem_rvalid, outstanding SHALL decrement. If drop_cnt = 0, {pc, imem_rdata} SHALL be pushed, with pc taken from an internal response-PC counter. If drop_cnt != 0, the word SHALL be discarded and drop_cnt SHALL decrement.
REQ-020 InstrValidF SHALL be (count != 0) and (drop path idle at head); InstrF and PCF SHALL be the head entry. When empty, InstrF SHALL be 32'h0000_0013 (NOP) and PCF SHALL hold its last value.
REQ-021 The head SHALL be popped when InstrValidF = 1, StallF = 0 and PCSrcE = 0.
REQ-022 Latency: a word granted in cycle N with rvalid in cycle N+1 SHALL appear on InstrF in cycle N+2 (registered; no rvalid-to-InstrF bypass).
REQ-023 Simultaneous push and pop SHALL be legal at any count, including full; count is unchanged.
REQ-024 On PCSrcE = 1, in the same edge: FIFO count SHALL go to 0, fetch_pc and the response-PC counter SHALL load PCTargetE, and drop_cnt SHALL load outstanding minus imem_rvalid. Any response arriving in the redirect cycle SHALL be discarded.
REQ-025 Redirect SHALL take priority over pop, push and StallF.
REQ-026 A redirect while drop_cnt != 0 SHALL reload drop_cnt per REQ-024. Outstanding still counts every undelivered response, so no stale word is ever pushed.
REQ-027 PCTargetE[1:0] SHALL be ignored; addresses are forced word-aligned.
REQ-028 The FIFO SHALL never overflow or underflow. Pushing when count = DEPTH with no pop is impossible by the credit rule.

Reset
REQ-029 While reset = 1: imem_req = 0, count = outstanding = drop_cnt = 0, fetch_pc = response-PC = RESET_PC, InstrValidF = 0, InstrF = NOP, PCF = RESET_PC.
REQ-030 Reset SHALL override an in-flight redirect. The memory SHALL be reset in the same cycle, so no stale responses are expected after reset.

Structure
REQ-031 Package fetch_pkg SHALL hold fetch_entry_t {pc[31:0], instr[31:0]}, the constant NOP_INSTR = 32'h0000_0013 and DEPTH_DEFAULT = 4.
REQ-032 Storage SHALL be one sub-module, sync_fifo, holding the pointer-based FIFO of fetch_entry_t with push, pop, flush, count, head and full/empty. Credit, drop and redirect logic SHALL remain in fetch_queue.

Verification
REQ-033 Scenario: release reset, gnt=1, rvalid one cycle after each grant, StallF=0 -> PCF sequence 0, 4, 8, 12 on consecutive cycles from cycle 2, with InstrF matching the memory contents.
REQ-034 Scenario: StallF=1 for 10 cycles -> exactly 4 grants, imem_req=0 afterwards; the head stays at PC 0 with InstrValidF=1.
REQ-035 Scenario: PCSrcE=1 with PCTargetE=0x100 while 3 fetches are outstanding -> the 3 late responses are discarded, the next InstrF has PCF=0x100, and no PC 0x0C/0x10 instruction is ever valid.
REQ-036 Scenario: PCTargetE=0x103 -> imem_addr=0x100.
REQ-037 Scenario: fetch_pc=0xFFFF_FFFC -> the next imem_addr is 0x0000_0000.
REQ-038 Scenario: reset asserted for one cycle mid-burst with 2 fetches outstanding -> all outputs take their REQ-029 values the following cycle and fetching restarts at RESET_PC.
